// File: rtl/snn_seq_pkg.sv
// Shared types for the SNN run sequencer: FSM state encoding and run status codes.
package snn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORT   = 2'd2
    } run_err_e;

endpackage

// File: rtl/snn_seq_watchdog.sv
// Per-step watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module snn_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TO_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TO_W-1:0] count_r;

    // Watchdog counter; holds at the terminal count instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TO_W{1'b0}};
        end else if (clear) begin
            count_r <= {TO_W{1'b0}};
        end else if (enable && (count_r != LAST_COUNT)) begin
            count_r <= count_r + TO_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/snn_run_sequencer.sv
// Host-side run sequencer: one acc_start pulse per timestep, completion/gap/timeout
// handling and run status. Optional counters run_cycles/max_step_lat: SNN_RUN_SEQ_PERF_EN.
module snn_run_sequencer #(
    parameter int unsigned STEP_W         = 16,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TO_W           = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic [STEP_W-1:0] run_steps,
    input  logic              run_abort,
    output logic              run_busy,
    output logic              run_done,
    output logic [1:0]        run_err,
    output logic [STEP_W-1:0] steps_done,
    output logic              acc_start,
    input  logic              acc_done
`ifdef SNN_RUN_SEQ_PERF_EN
    ,
    output logic [31:0]       run_cycles,
    output logic [TO_W-1:0]   max_step_lat
`endif
);

    import snn_seq_pkg::*;

    localparam int unsigned GAP_W = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 1;

    seq_state_e        state_r;
    seq_state_e        state_s;
    run_err_e          err_r;
    logic [STEP_W-1:0] target_r;
    logic [STEP_W-1:0] steps_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              done_q_r;
    logic              busy_r;
    logic              run_done_r;
    logic              acc_start_r;

    logic done_rise_s;
    logic accept_s;
    logic active_s;
    logic abort_s;
    logic step_inc_s;
    logic timeout_s;
    logic last_step_s;
    logic gap_end_s;
    logic wd_expired_s;

    // A done level already high when WAIT is entered never counts: only edges do.
    assign done_rise_s = acc_done & ~done_q_r;
    assign accept_s    = (state_r == IDLE) & run_req;
    assign active_s    = (state_r == START) | (state_r == WAIT) | (state_r == GAP);
    assign abort_s     = active_s & run_abort;
    // Abort wins over a same-cycle completion or timeout.
    assign step_inc_s  = (state_r == WAIT) & ~run_abort & done_rise_s;
    assign timeout_s   = (state_r == WAIT) & ~run_abort & ~done_rise_s & wd_expired_s;
    assign last_step_s = (steps_r + STEP_W'(1)) == target_r;
    assign gap_end_s   = (32'(gap_cnt_r) + 32'd1) >= GAP_CYCLES;

    snn_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_r == START),
        .enable  (state_r == WAIT),
        .expired (wd_expired_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (run_req) begin
                    if (run_steps == {STEP_W{1'b0}}) begin
                        state_s = FINISH;
                    end else begin
                        state_s = START;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (abort_s) begin
                    state_s = FINISH;
                end else begin
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (abort_s || timeout_s) begin
                    state_s = FINISH;
                end else if (step_inc_s) begin
                    if (last_step_s) begin
                        state_s = FINISH;
                    end else if (GAP_CYCLES == 32'd0) begin
                        state_s = START;
                    end else begin
                        state_s = GAP;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            GAP: begin
                if (abort_s) begin
                    state_s = FINISH;
                end else if (gap_end_s) begin
                    state_s = START;
                end else begin
                    state_s = GAP;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and handshake registers; acc_start follows the next state so it lines up with START
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            done_q_r    <= 1'b0;
            acc_start_r <= 1'b0;
            run_done_r  <= 1'b0;
            busy_r      <= 1'b0;
            gap_cnt_r   <= {GAP_W{1'b0}};
        end else begin
            state_r     <= state_s;
            done_q_r    <= acc_done;
            acc_start_r <= (state_s == START);
            run_done_r  <= (state_r == FINISH);
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (run_done_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
        end
    end

    // Run bookkeeping: target, completed steps and status
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r <= {STEP_W{1'b0}};
            steps_r  <= {STEP_W{1'b0}};
            err_r    <= ERR_OK;
        end else if (accept_s) begin
            target_r <= run_steps;
            steps_r  <= {STEP_W{1'b0}};
            err_r    <= ERR_OK;
        end else begin
            if (step_inc_s && (steps_r != target_r)) begin
                steps_r <= steps_r + STEP_W'(1);
            end else begin
                steps_r <= steps_r;
            end
            if (abort_s) begin
                err_r <= ERR_ABORT;
            end else if (timeout_s) begin
                err_r <= ERR_TIMEOUT;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign run_busy   = busy_r;
    assign run_done   = run_done_r;
    assign run_err    = err_r;
    assign steps_done = steps_r;
    assign acc_start  = acc_start_r;

`ifdef SNN_RUN_SEQ_PERF_EN
    logic [31:0]     run_cycles_r;
    logic [TO_W-1:0] lat_r;
    logic [TO_W-1:0] max_lat_r;

    // Run length (acceptance cycle counted as 1) and worst START-to-done latency
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles_r <= 32'd0;
            lat_r        <= {TO_W{1'b0}};
            max_lat_r    <= {TO_W{1'b0}};
        end else begin
            if (accept_s) begin
                run_cycles_r <= 32'd1;
            end else if (busy_r && (run_cycles_r != 32'hFFFF_FFFF)) begin
                run_cycles_r <= run_cycles_r + 32'd1;
            end else begin
                run_cycles_r <= run_cycles_r;
            end
            if (state_r == START) begin
                lat_r <= TO_W'(1);
            end else if ((state_r == WAIT) && (lat_r != {TO_W{1'b1}})) begin
                lat_r <= lat_r + TO_W'(1);
            end else begin
                lat_r <= lat_r;
            end
            if (accept_s) begin
                max_lat_r <= {TO_W{1'b0}};
            end else if (step_inc_s && (lat_r > max_lat_r)) begin
                max_lat_r <= lat_r;
            end else begin
                max_lat_r <= max_lat_r;
            end
        end
    end

    assign run_cycles   = run_cycles_r;
    assign max_step_lat = max_lat_r;
`endif

endmodule

// File: tb/tb_snn_run_sequencer.sv
// Self-checking bench for snn_run_sequencer: behavioural accelerator model plus a
// timeline reference model of start/done cycles, status and step counts.
module tb_snn_run_sequencer;

    localparam int STEP_W = 16;
    localparam int GAP    = 2;
    localparam int TMO    = 50;
    localparam int TO_W   = 17;

    logic              clk;
    logic              rst;
    logic              run_req;
    logic [STEP_W-1:0] run_steps;
    logic              run_abort;
    logic              run_busy;
    logic              run_done;
    logic [1:0]        run_err;
    logic [STEP_W-1:0] steps_done;
    logic              acc_start;
    logic              acc_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // accelerator model controls: mode 0 = pulse acc_lat cycles after start, 1 = follow man_done
    int   acc_mode = 0;
    int   acc_lat  = 20;
    logic man_done = 1'b0;

    int                start_q[$];
    int                done_cyc_q[$];
    logic [1:0]        done_err_q[$];
    logic [STEP_W-1:0] done_steps_q[$];
    logic              done_busy_q[$];

    int exp_starts[$];
    int exp_done;
    int exp_err;
    int exp_steps;

    snn_run_sequencer #(
        .STEP_W         (STEP_W),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .run_steps  (run_steps),
        .run_abort  (run_abort),
        .run_busy   (run_busy),
        .run_done   (run_done),
        .run_err    (run_err),
        .steps_done (steps_done),
        .acc_start  (acc_start),
        .acc_done   (acc_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (acc_start) start_q.push_back(cyc);
        if (run_done) begin
            done_cyc_q.push_back(cyc);
            done_err_q.push_back(run_err);
            done_steps_q.push_back(steps_done);
            done_busy_q.push_back(run_busy);
        end
    end

    initial begin : acc_model
        int due;
        bit pending;
        due = 0;
        pending = 1'b0;
        acc_done = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_mode == 1) begin
                acc_done = man_done;
                pending = 1'b0;
            end else begin
                acc_done = 1'b0;
                if (acc_start) begin
                    due = cyc + acc_lat;
                    pending = 1'b1;
                end
                if (pending && cyc == due) begin
                    acc_done = 1'b1;
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic at_cycle_post(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    task automatic clear_logs();
        start_q.delete();
        done_cyc_q.delete();
        done_err_q.delete();
        done_steps_q.delete();
        done_busy_q.delete();
    endtask

    task automatic start_run(input int steps, output int req_cyc);
        @(negedge clk);
        run_req   = 1'b1;
        run_steps = STEP_W'(steps);
        req_cyc   = cyc;
        @(negedge clk);
        run_req   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cyc_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Timeline model: START one cycle after request, done edge lat cycles after each
    // START, gap then next START; a step whose lat exceeds the timeout ends the run.
    task automatic predict(input int r, input int n, input int lat);
        int s;
        exp_starts.delete();
        exp_err   = 0;
        exp_steps = 0;
        exp_done  = r + 2;
        s = r + 1;
        for (int k = 0; k < n; k++) begin
            exp_starts.push_back(s);
            if (lat > TMO) begin
                exp_err  = 1;
                exp_done = s + TMO + 2;
                break;
            end
            exp_steps++;
            if (exp_steps == n) begin
                exp_done = s + lat + 2;
                break;
            end
            s = s + 1 + lat + GAP;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL reset_acc_start got %b want 0", acc_start); end
        checks++; if (run_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", run_busy); end
        checks++; if (run_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", run_done); end
        checks++; if (run_err !== 2'd0) begin errors++; $display("FAIL reset_err got %0d want 0", run_err); end
        checks++; if (steps_done !== 16'd0) begin errors++; $display("FAIL reset_steps got %0d want 0", steps_done); end
        rst = 1'b0;
        idle(3);
        checks++; if (run_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", run_busy); end
    endtask

    task automatic test_three_step();
        int r;
        bit ok;
        clear_logs();
        acc_mode = 0;
        acc_lat  = 20;
        start_run(3, r);
        wait_done(300, ok);
        idle(3);
        checks++; if (!ok) begin errors++; $display("FAIL three_step_wait got no run_done want run_done"); end
        checks++;
        if (start_q.size() != 3) begin
            errors++; $display("FAIL three_step_starts got %0d want 3", start_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (start_q[k] != r + 1 + 23 * k) begin
                    errors++; $display("FAIL three_step_start%0d got %0d want %0d", k, start_q[k], r + 1 + 23 * k);
                end
            end
        end
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++; $display("FAIL three_step_done_count got %0d want 1", done_cyc_q.size());
        end else begin
            checks++; if (done_cyc_q[0] != r + 69) begin errors++; $display("FAIL three_step_done_cycle got %0d want %0d", done_cyc_q[0], r + 69); end
            checks++; if (done_err_q[0] !== 2'd0) begin errors++; $display("FAIL three_step_err got %0d want 0", done_err_q[0]); end
            checks++; if (done_steps_q[0] !== 16'd3) begin errors++; $display("FAIL three_step_steps got %0d want 3", done_steps_q[0]); end
            checks++; if (done_busy_q[0] !== 1'b1) begin errors++; $display("FAIL three_step_busy_at_done got %b want 1", done_busy_q[0]); end
        end
        checks++; if (run_busy !== 1'b0) begin errors++; $display("FAIL three_step_busy_after got %b want 0", run_busy); end
    endtask

    task automatic test_zero_steps();
        int r;
        bit ok;
        clear_logs();
        start_run(0, r);
        wait_done(20, ok);
        idle(3);
        checks++; if (!ok) begin errors++; $display("FAIL zero_wait got no run_done want run_done"); end
        checks++; if (start_q.size() != 0) begin errors++; $display("FAIL zero_starts got %0d want 0", start_q.size()); end
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++; $display("FAIL zero_done_count got %0d want 1", done_cyc_q.size());
        end else begin
            checks++; if (done_cyc_q[0] != r + 2) begin errors++; $display("FAIL zero_done_cycle got %0d want %0d", done_cyc_q[0], r + 2); end
            checks++; if (done_err_q[0] !== 2'd0) begin errors++; $display("FAIL zero_err got %0d want 0", done_err_q[0]); end
            checks++; if (done_steps_q[0] !== 16'd0) begin errors++; $display("FAIL zero_steps got %0d want 0", done_steps_q[0]); end
        end
    endtask

    task automatic test_timeout();
        int r;
        bit ok;
        clear_logs();
        man_done = 1'b0;
        acc_mode = 1;
        idle(2);
        start_run(2, r);
        wait_done(200, ok);
        idle(5);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_wait got no run_done want run_done"); end
        checks++; if (start_q.size() != 1) begin errors++; $display("FAIL timeout_starts got %0d want 1", start_q.size()); end
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++; $display("FAIL timeout_done_count got %0d want 1", done_cyc_q.size());
        end else begin
            checks++; if (done_cyc_q[0] != r + 1 + TMO + 2) begin errors++; $display("FAIL timeout_done_cycle got %0d want %0d", done_cyc_q[0], r + 1 + TMO + 2); end
            checks++; if (done_err_q[0] !== 2'd1) begin errors++; $display("FAIL timeout_err got %0d want 1", done_err_q[0]); end
            checks++; if (done_steps_q[0] !== 16'd0) begin errors++; $display("FAIL timeout_steps got %0d want 0", done_steps_q[0]); end
        end
        checks++; if (run_err !== 2'd1) begin errors++; $display("FAIL timeout_err_held got %0d want 1", run_err); end
        acc_mode = 0;
        idle(2);
    endtask

    task automatic test_abort();
        int r;
        bit ok;
        clear_logs();
        acc_mode = 0;
        acc_lat  = 20;
        start_run(5, r);
        while (cyc < r + 44) @(negedge clk);
        run_abort = 1'b1;
        @(negedge clk);
        run_abort = 1'b0;
        wait_done(20, ok);
        idle(30);
        checks++; if (!ok) begin errors++; $display("FAIL abort_wait got no run_done want run_done"); end
        checks++;
        if (start_q.size() != 2) begin
            errors++; $display("FAIL abort_starts got %0d want 2", start_q.size());
        end else begin
            checks++; if (start_q[1] != r + 24) begin errors++; $display("FAIL abort_start2 got %0d want %0d", start_q[1], r + 24); end
        end
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++; $display("FAIL abort_done_count got %0d want 1", done_cyc_q.size());
        end else begin
            checks++; if (done_cyc_q[0] != r + 46) begin errors++; $display("FAIL abort_done_cycle got %0d want %0d", done_cyc_q[0], r + 46); end
            checks++; if (done_err_q[0] !== 2'd2) begin errors++; $display("FAIL abort_err got %0d want 2", done_err_q[0]); end
            checks++; if (done_steps_q[0] !== 16'd1) begin errors++; $display("FAIL abort_steps got %0d want 1", done_steps_q[0]); end
        end
    endtask

    task automatic test_held_done();
        int r;
        bit ok;
        clear_logs();
        acc_mode = 1;
        at_cycle_post(cyc + 1);
        man_done = 1'b1;
        idle(4);
        start_run(1, r);
        at_cycle_post(r + 11);
        man_done = 1'b0;
        at_cycle_post(r + 13);
        man_done = 1'b1;
        wait_done(100, ok);
        idle(2);
        checks++; if (!ok) begin errors++; $display("FAIL held_rise_wait got no run_done want run_done"); end
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++; $display("FAIL held_rise_done_count got %0d want 1", done_cyc_q.size());
        end else begin
            checks++; if (done_cyc_q[0] != r + 15) begin errors++; $display("FAIL held_rise_done_cycle got %0d want %0d", done_cyc_q[0], r + 15); end
            checks++; if (done_err_q[0] !== 2'd0) begin errors++; $display("FAIL held_rise_err got %0d want 0", done_err_q[0]); end
            checks++; if (done_steps_q[0] !== 16'd1) begin errors++; $display("FAIL held_rise_steps got %0d want 1", done_steps_q[0]); end
        end
        clear_logs();
        idle(3);
        start_run(1, r);
        wait_done(200, ok);
        idle(2);
        checks++; if (!ok) begin errors++; $display("FAIL held_level_wait got no run_done want run_done"); end
        checks++;
        if (done_cyc_q.size() != 1) begin
            errors++; $display("FAIL held_level_done_count got %0d want 1", done_cyc_q.size());
        end else begin
            checks++; if (done_cyc_q[0] != r + 1 + TMO + 2) begin errors++; $display("FAIL held_level_done_cycle got %0d want %0d", done_cyc_q[0], r + 1 + TMO + 2); end
            checks++; if (done_err_q[0] !== 2'd1) begin errors++; $display("FAIL held_level_err got %0d want 1", done_err_q[0]); end
            checks++; if (done_steps_q[0] !== 16'd0) begin errors++; $display("FAIL held_level_steps got %0d want 0", done_steps_q[0]); end
        end
        at_cycle_post(cyc + 1);
        man_done = 1'b0;
        idle(3);
        acc_mode = 0;
        idle(2);
    endtask

    task automatic test_busy_req_and_reset();
        int r;
        clear_logs();
        acc_mode = 0;
        acc_lat  = 20;
        start_run(3, r);
        while (cyc < r + 10) @(negedge clk);
        checks++; if (run_busy !== 1'b1) begin errors++; $display("FAIL busy_mid_run got %b want 1", run_busy); end
        run_req   = 1'b1;
        run_steps = 16'd7;
        @(negedge clk);
        run_req   = 1'b0;
        while (cyc < r + 29) @(negedge clk);
        checks++; if (steps_done !== 16'd1) begin errors++; $display("FAIL busy_steps_before_rst got %0d want 1", steps_done); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL rst_mid_acc_start got %b want 0", acc_start); end
        checks++; if (run_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", run_busy); end
        checks++; if (steps_done !== 16'd0) begin errors++; $display("FAIL rst_mid_steps got %0d want 0", steps_done); end
        checks++; if (run_err !== 2'd0) begin errors++; $display("FAIL rst_mid_err got %0d want 0", run_err); end
        rst = 1'b0;
        idle(70);
        checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL rst_mid_done_pulses got %0d want 0", done_cyc_q.size()); end
        checks++;
        if (start_q.size() != 2) begin
            errors++; $display("FAIL rst_mid_starts got %0d want 2", start_q.size());
        end else begin
            checks++; if (start_q[1] != r + 24) begin errors++; $display("FAIL busy_req_start2 got %0d want %0d", start_q[1], r + 24); end
        end
    endtask

    task automatic test_random();
        int r;
        int n;
        int lat;
        bit ok;
        for (int it = 0; it < 10; it++) begin
            n   = $urandom_range(0, 4);
            lat = $urandom_range(1, 60);
            if (it == 0) begin n = 2; lat = TMO; end
            if (it == 1) begin n = 2; lat = TMO + 1; end
            clear_logs();
            acc_mode = 0;
            acc_lat  = lat;
            start_run(n, r);
            predict(r, n, lat);
            wait_done(400, ok);
            idle(2);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_wait got no run_done want run_done (n=%0d lat=%0d)", it, n, lat); end
            checks++;
            if (start_q.size() != exp_starts.size()) begin
                errors++; $display("FAIL rand%0d_starts got %0d want %0d (n=%0d lat=%0d)", it, start_q.size(), exp_starts.size(), n, lat);
            end else begin
                for (int k = 0; k < exp_starts.size(); k++) begin
                    checks++;
                    if (start_q[k] != exp_starts[k]) begin
                        errors++; $display("FAIL rand%0d_start%0d got %0d want %0d", it, k, start_q[k], exp_starts[k]);
                    end
                end
            end
            checks++;
            if (done_cyc_q.size() != 1) begin
                errors++; $display("FAIL rand%0d_done_count got %0d want 1", it, done_cyc_q.size());
            end else begin
                checks++; if (done_cyc_q[0] != exp_done) begin errors++; $display("FAIL rand%0d_done_cycle got %0d want %0d", it, done_cyc_q[0], exp_done); end
                checks++; if (done_err_q[0] !== 2'(exp_err)) begin errors++; $display("FAIL rand%0d_err got %0d want %0d", it, done_err_q[0], exp_err); end
                checks++; if (done_steps_q[0] !== STEP_W'(exp_steps)) begin errors++; $display("FAIL rand%0d_steps got %0d want %0d", it, done_steps_q[0], exp_steps); end
            end
            idle(12);
            checks++; if (run_err !== 2'(exp_err)) begin errors++; $display("FAIL rand%0d_err_held got %0d want %0d", it, run_err, exp_err); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        run_req   = 1'b0;
        run_steps = 16'd0;
        run_abort = 1'b0;
        test_reset();
        test_three_step();
        test_zero_steps();
        test_timeout();
        test_abort();
        test_held_done();
        test_busy_req_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
